// File: rtl/gemm_tile_controller.sv
// gemm_tile_controller
//   Sequencer for the tiled GeMM datapath. Latches the tile counts on start,
//   walks output tiles M-outer / N-middle / K-inner, and drives the SRAM
//   A/B/C word addresses, MAC accumulate/clear strobes and C write strobe.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 start request, sampled only in IDLE
//   M_size_i/K_size_i/N_size_i  runtime matrix sizes (elements)
//   sram_a_addr_o           A word address (mt*Kt + kt)
//   sram_b_addr_o           B word address (kt*Nt + nt)
//   sram_c_addr_o           C word address, valid with sram_c_we_o
//   sram_c_we_o             C write enable
//   mac_en_o                A/B read data valid; MAC array accumulates
//   mac_clear_o             with mac_en_o: load product (first K step)
//   busy_o                  run in progress (RUN and DRAIN)
//   done_o                  one-cycle completion pulse
module gemm_tile_controller #(
    parameter int unsigned M             = 4,
    parameter int unsigned N             = 4,
    parameter int unsigned K             = 4,
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned SizeAddrWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     mac_en_o,
    output logic                     mac_clear_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned MShift = $clog2(M);
    localparam int unsigned NShift = $clog2(N);
    localparam int unsigned KShift = $clog2(K);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [SizeAddrWidth-1:0] m_tiles_in, k_tiles_in, n_tiles_in;
    logic                     zero_in;
    logic [SizeAddrWidth-1:0] m_tiles, k_tiles, n_tiles;
    logic [SizeAddrWidth-1:0] mt, nt, kt, nt_inc;
    logic [AddrWidth-1:0]     a_base, a_addr, b_addr, c_addr;
    logic [AddrWidth-1:0]     k_step, n_step;
    logic                     last_k, last_n, last_m, last_issue;
    logic                     drain_cnt;

    logic                     s1_valid, s1_clear, s1_last_k;
    logic [AddrWidth-1:0]     s1_c_addr;
    logic                     s2_we;
    logic [AddrWidth-1:0]     s2_c_addr;

    // Power-of-two tile sizes: floor division is a right shift.
    assign m_tiles_in = M_size_i >> MShift;
    assign k_tiles_in = K_size_i >> KShift;
    assign n_tiles_in = N_size_i >> NShift;
    assign zero_in    = (m_tiles_in == '0) || (k_tiles_in == '0) || (n_tiles_in == '0);

    assign k_step = AddrWidth'(k_tiles);
    assign n_step = AddrWidth'(n_tiles);
    assign nt_inc = nt + SizeAddrWidth'(1);

    assign last_k     = (kt == k_tiles - SizeAddrWidth'(1));
    assign last_n     = (nt == n_tiles - SizeAddrWidth'(1));
    assign last_m     = (mt == m_tiles - SizeAddrWidth'(1));
    assign last_issue = last_k && last_n && last_m;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = zero_in ? DONE : RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (drain_cnt) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drain_cnt <= 1'b0;
        end else if (state == DRAIN) begin
            drain_cnt <= ~drain_cnt;
        end else begin
            drain_cnt <= 1'b0;
        end
    end

    // ---------------- Stage 0: address issue ----------------
    // Counters stop on the last issue so DRAIN holds the final addresses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_tiles <= '0;
            k_tiles <= '0;
            n_tiles <= '0;
            mt      <= '0;
            nt      <= '0;
            kt      <= '0;
            a_base  <= '0;
            a_addr  <= '0;
            b_addr  <= '0;
            c_addr  <= '0;
        end else if (state == IDLE) begin
            if (start_i) begin
                m_tiles <= m_tiles_in;
                k_tiles <= k_tiles_in;
                n_tiles <= n_tiles_in;
                mt      <= '0;
                nt      <= '0;
                kt      <= '0;
                a_base  <= '0;
                a_addr  <= '0;
                b_addr  <= '0;
                c_addr  <= '0;
            end
        end else if (state == RUN && !last_issue) begin
            if (!last_k) begin
                kt     <= kt + SizeAddrWidth'(1);
                a_addr <= a_addr + AddrWidth'(1);
                b_addr <= b_addr + n_step;
            end else begin
                kt     <= '0;
                c_addr <= c_addr + AddrWidth'(1);
                if (!last_n) begin
                    // Next tile in the same A row: rewind A, B restarts at column nt+1.
                    nt     <= nt_inc;
                    a_addr <= a_base;
                    b_addr <= AddrWidth'(nt_inc);
                end else begin
                    nt     <= '0;
                    mt     <= mt + SizeAddrWidth'(1);
                    a_base <= a_base + k_step;
                    a_addr <= a_base + k_step;
                    b_addr <= '0;
                end
            end
        end
    end

    // ---------------- Stages 1 and 2 ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_clear  <= 1'b0;
            s1_last_k <= 1'b0;
            s1_c_addr <= '0;
            s2_we     <= 1'b0;
            s2_c_addr <= '0;
        end else begin
            s1_valid  <= (state == RUN);
            s1_clear  <= (kt == '0);
            s1_last_k <= last_k;
            s1_c_addr <= c_addr;
            s2_we     <= s1_valid && s1_last_k;
            s2_c_addr <= s1_c_addr;
        end
    end

    assign sram_a_addr_o = (state == RUN || state == DRAIN) ? a_addr : '0;
    assign sram_b_addr_o = (state == RUN || state == DRAIN) ? b_addr : '0;
    assign sram_c_addr_o = s2_we ? s2_c_addr : '0;
    assign sram_c_we_o   = s2_we;
    assign mac_en_o      = s1_valid;
    assign mac_clear_o   = s1_valid && s1_clear;
    assign busy_o        = (state == RUN) || (state == DRAIN);
    assign done_o        = (state == DONE);

endmodule

// File: tb/tb_gemm_tile_controller.sv
// tb_gemm_tile_controller
//   Directed bench for gemm_tile_controller. Each run is captured per cycle
//   relative to the start cycle s (offset 0 = s) and compared with
//   hand-computed address sequences and per-cycle strobe masks.
module tb_gemm_tile_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  M_size_i, K_size_i, N_size_i;
    logic [11:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic        sram_c_we_o, mac_en_o, mac_clear_o, busy_o, done_o;

    gemm_tile_controller #(
        .M(4), .N(4), .K(4), .AddrWidth(12), .SizeAddrWidth(8)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .M_size_i      (M_size_i),
        .K_size_i      (K_size_i),
        .N_size_i      (N_size_i),
        .sram_a_addr_o (sram_a_addr_o),
        .sram_b_addr_o (sram_b_addr_o),
        .sram_c_addr_o (sram_c_addr_o),
        .sram_c_we_o   (sram_c_we_o),
        .mac_en_o      (mac_en_o),
        .mac_clear_o   (mac_clear_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          a_log[16];
    int          b_log[16];
    logic [15:0] we_m, en_m, clr_m, done_m, busy_m;
    int          c_q[$];

    function automatic logic [63:0] all_outputs();
        return {23'd0, sram_a_addr_o, sram_b_addr_o, sram_c_addr_o,
                sram_c_we_o, mac_en_o, mac_clear_o, busy_o, done_o};
    endfunction

    task automatic sample(input int i);
        a_log[i]  = int'(sram_a_addr_o);
        b_log[i]  = int'(sram_b_addr_o);
        we_m[i]   = sram_c_we_o;
        en_m[i]   = mac_en_o;
        clr_m[i]  = mac_clear_o;
        done_m[i] = done_o;
        busy_m[i] = busy_o;
        if (sram_c_we_o) c_q.push_back(int'(sram_c_addr_o));
    endtask

    // Start a run at the next negedge and record 16 cycles. disturb toggles
    // start and scrambles sizes during RUN/DRAIN; rst_at (>0) asserts reset
    // mid-cycle at that offset.
    task automatic capture(input int m, input int k, input int n,
                           input bit disturb, input int rst_at);
        c_q.delete();
        we_m = '0; en_m = '0; clr_m = '0; done_m = '0; busy_m = '0;
        @(negedge clk_i);
        sample(0);
        M_size_i = 8'(m);
        K_size_i = 8'(k);
        N_size_i = 8'(n);
        start_i  = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk_i);
            sample(i);
            if (disturb && i <= 10) begin
                start_i  = (i % 2 == 1);
                M_size_i = 8'(i * 37);
                K_size_i = 8'(i * 11 + 3);
                N_size_i = 8'(255 - i * 13);
            end else begin
                start_i  = 1'b0;
                M_size_i = 8'(m);
                K_size_i = 8'(k);
                N_size_i = 8'(n);
            end
            if (i == rst_at) begin
                #1 rst_i = 1'b1;
                #1 check_eq($sformatf("rst_async_zero@%0d", i), all_outputs(), 64'd0);
            end
            if (rst_at > 0 && i == rst_at + 1) rst_i = 1'b0;
        end
    endtask

    task automatic check_run(input string tag, input int t, input int ea[8], input int eb[8],
                             input logic [15:0] en, input logic [15:0] clr,
                             input logic [15:0] we, input logic [15:0] dn,
                             input logic [15:0] bs, input int nwrites);
        for (int i = 0; i < t; i++) begin
            check_eq($sformatf("%s_a[s+%0d]", tag, i + 1), 64'(a_log[i + 1]), 64'(ea[i]));
            check_eq($sformatf("%s_b[s+%0d]", tag, i + 1), 64'(b_log[i + 1]), 64'(eb[i]));
        end
        check_eq({tag, "_mac_en"},    64'(en_m),   64'(en));
        check_eq({tag, "_mac_clear"}, 64'(clr_m),  64'(clr));
        check_eq({tag, "_c_we"},      64'(we_m),   64'(we));
        check_eq({tag, "_done"},      64'(done_m), 64'(dn));
        check_eq({tag, "_busy"},      64'(busy_m), 64'(bs));
        check_eq({tag, "_nwrites"},   64'(c_q.size()), 64'(nwrites));
        for (int j = 0; j < c_q.size(); j++)
            check_eq($sformatf("%s_c_addr%0d", tag, j), 64'(c_q[j]), 64'(j));
    endtask

    initial begin
        logic [15:0] idle_we, idle_done;
        rst_i    = 1'b1;
        start_i  = 1'b0;
        M_size_i = '0;
        K_size_i = '0;
        N_size_i = '0;

        #12 check_eq("reset_outputs", all_outputs(), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_we = '0; idle_done = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            idle_we[i]   = sram_c_we_o;
            idle_done[i] = done_o;
        end
        check_eq("idle_no_we",   64'(idle_we),   64'd0);
        check_eq("idle_no_done", 64'(idle_done), 64'd0);

        // 8/8/8: Mt=Nt=Kt=2, T=8
        capture(8, 8, 8, 1'b0, 0);
        check_run("r888", 8, '{0,1,0,1,2,3,2,3}, '{0,2,1,3,0,2,1,3},
                  16'h03FC, 16'h0154, 16'h0550, 16'h0800, 16'h07FE, 4);
        check_eq("r888_a_idle",   64'(a_log[0]),  64'd0);
        check_eq("r888_a_drain",  64'(a_log[10]), 64'd3);
        check_eq("r888_b_drain",  64'(b_log[10]), 64'd3);
        check_eq("r888_a_done",   64'(a_log[11]), 64'd0);
        check_eq("r888_b_done",   64'(b_log[11]), 64'd0);

        // M=4, K=4, N=8: Mt=1, Kt=1, Nt=2, T=2
        capture(4, 4, 8, 1'b0, 0);
        check_run("r448", 2, '{0,0,0,0,0,0,0,0}, '{0,1,0,0,0,0,0,0},
                  16'h000C, 16'h000C, 16'h0018, 16'h0020, 16'h001E, 2);

        // 7/6/5 truncates to 1 tile, T=1
        capture(7, 6, 5, 1'b0, 0);
        check_run("r765", 1, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0},
                  16'h0004, 16'h0004, 16'h0008, 16'h0010, 16'h000E, 1);

        // 3/8/8: Mt=0, zero-tile run
        capture(3, 8, 8, 1'b0, 0);
        check_run("r388", 0, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0},
                  16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 0);

        // M=8, K=12, N=4: Mt=2, Kt=3, Nt=1, T=6
        capture(8, 12, 4, 1'b0, 0);
        check_run("r8124", 6, '{0,1,2,3,4,5,0,0}, '{0,1,2,0,1,2,0,0},
                  16'h00FC, 16'h0024, 16'h0120, 16'h0200, 16'h01FE, 2);

        // 8/8/8 with start pulses and size changes during RUN/DRAIN
        capture(8, 8, 8, 1'b1, 0);
        check_run("r888dist", 8, '{0,1,0,1,2,3,2,3}, '{0,2,1,3,0,2,1,3},
                  16'h03FC, 16'h0154, 16'h0550, 16'h0800, 16'h07FE, 4);

        // Reset at s+5 of 8/8/8: only the s+4 write survives, no done
        capture(8, 8, 8, 1'b0, 5);
        check_run("r888rst", 4, '{0,1,0,1,0,0,0,0}, '{0,2,1,3,0,0,0,0},
                  16'h003C, 16'h0014, 16'h0010, 16'h0000, 16'h003E, 1);

        // Full run after reset recovery
        capture(8, 8, 8, 1'b0, 0);
        check_run("r888post", 8, '{0,1,0,1,2,3,2,3}, '{0,2,1,3,0,2,1,3},
                  16'h03FC, 16'h0154, 16'h0550, 16'h0800, 16'h07FE, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
